// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch controller
package fetch_ctrl_pkg;
  typedef logic u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
  localparam u64 PC_RESET_DEFAULT = 64'h8000_0000;
  typedef enum logic [1:0] {REQ, DISCARD, FULL} fetch_ctrl_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, runs the I-bus handshake and presents one fetched instruction at a time
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        hold,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        stallI
);
  fetch_ctrl_state_t state;
  u64 pc;
  u64 reqAddr;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= PC_RESET;
      reqAddr <= PC_RESET;
      state <= REQ;
      out_valid <= 1'b0;
      out_pc <= '0;
      out_instr <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      out_valid <= 1'b0;
      // an issued request cannot be withdrawn, so remember its address for DISCARD
      if (state != DISCARD) reqAddr <= pc;
      state <= (state == FULL || (state == REQ && iresp_ok)) ? REQ : DISCARD;
    end else begin
      case (state)
        REQ: if (iresp_ok) begin
          out_instr <= iresp_data;
          out_pc <= pc;
          out_valid <= 1'b1;
          pc <= pc + 64'd4;
          state <= FULL;
        end
        FULL: if (!hold) begin
          out_valid <= 1'b0;
          state <= REQ;
        end
        DISCARD: if (iresp_ok) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end
  always_comb begin
    ireq_valid = reset && state != FULL;
    ireq_addr = state == DISCARD ? reqAddr : pc;
    stallI = !out_valid;
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run against an instruction-stream model
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ireq_valid;
  logic [63:0] ireq_addr;
  logic iresp_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic hold = 1'b0;
  logic out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic stallI;
  int checks = 0;
  int fails = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .hold(hold), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .stallI(stallI)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [31:0] word(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    iresp_ok = 1'b0;
    redirect = 1'b0;
    hold = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || stallI !== 1'b1 || ireq_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold got v=%b s=%b rq=%b exp v=0 s=1 rq=0", out_valid, stallI, ireq_valid);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin
      fails++;
      $display("FAIL reset_first_req got rq=%b a=%h exp rq=1 a=80000000", ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    iresp_data = 32'h0000_0013;
    for (int i = 0; i < 6; i++) begin
      iresp_ok = ireq_valid;
      tick();
      checks++;
      if (out_valid !== (i % 2 == 0)) begin
        fails++;
        $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, i % 2 == 0);
      end
      if (i % 2 == 0) begin
        checks++;
        if (out_pc !== 64'h8000_0000 + 64'(4 * (i / 2)) || out_instr !== 32'h13) begin
          fails++;
          $display("FAIL stream_pc[%0d] got pc=%h i=%h exp pc=%h i=13", i, out_pc, out_instr,
                   64'h8000_0000 + 64'(4 * (i / 2)));
        end
      end
    end
    iresp_ok = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    iresp_data = 32'h0000_0013;
    iresp_ok = 1'b1;
    tick();
    iresp_ok = 1'b0;
    tick();
    iresp_ok = 1'b1;
    iresp_data = 32'h0000_0093;
    hold = 1'b1;
    tick();
    iresp_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h8000_0004 || out_instr !== 32'h93 || ireq_valid !== 1'b0) begin
        fails++;
        $display("FAIL hold_frozen[%0d] got v=%b pc=%h i=%h rq=%b exp v=1 pc=80000004 i=93 rq=0",
                 i, out_valid, out_pc, out_instr, ireq_valid);
      end
    end
    hold = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0008) begin
      fails++;
      $display("FAIL hold_release got v=%b rq=%b a=%h exp v=0 rq=1 a=80000008", out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 64'h8000_1000;
    tick();
    redirect = 1'b0;
    checks++;
    if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL discard_oldaddr got rq=%b a=%h v=%b exp rq=1 a=80000000 v=0", ireq_valid, ireq_addr, out_valid);
    end
    tick();
    tick();
    iresp_ok = 1'b1;
    iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_ok = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin
      fails++;
      $display("FAIL discard_drop got v=%b rq=%b a=%h exp v=0 rq=1 a=80001000", out_valid, ireq_valid, ireq_addr);
    end
    iresp_ok = 1'b1;
    iresp_data = 32'h0000_0013;
    tick();
    iresp_ok = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_1000 || out_instr !== 32'h13) begin
      fails++;
      $display("FAIL discard_target got v=%b pc=%h i=%h exp v=1 pc=80001000 i=13", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    iresp_ok = 1'b1;
    iresp_data = 32'hDEAD_BEEF;
    redirect = 1'b1;
    redirect_pc = 64'h8000_0200;
    tick();
    redirect = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200) begin
      fails++;
      $display("FAIL redir_ok got v=%b rq=%b a=%h exp v=0 rq=1 a=80000200", out_valid, ireq_valid, ireq_addr);
    end
    iresp_data = 32'h0000_0013;
    tick();
    iresp_ok = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_0200) begin
      fails++;
      $display("FAIL redir_ok_fetch got v=%b pc=%h exp v=1 pc=80000200", out_valid, out_pc);
    end
    hold = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h8000_0301;
    tick();
    redirect = 1'b0;
    hold = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || stallI !== 1'b1 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0301) begin
      fails++;
      $display("FAIL redir_full got v=%b s=%b rq=%b a=%h exp v=0 s=1 rq=1 a=80000301",
               out_valid, stallI, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_reset_discard();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 64'h8000_2000;
    tick();
    redirect = 1'b0;
    reset = 1'b0;
    iresp_ok = 1'b1;
    iresp_data = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1;
    iresp_ok = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin
      fails++;
      $display("FAIL rst_discard got v=%b rq=%b a=%h exp v=0 rq=1 a=80000000", out_valid, ireq_valid, ireq_addr);
    end
    iresp_ok = 1'b1;
    iresp_data = 32'h0000_0013;
    tick();
    iresp_ok = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || out_instr !== 32'h13) begin
      fails++;
      $display("FAIL rst_discard_fetch got v=%b pc=%h i=%h exp v=1 pc=80000000 i=13", out_valid, out_pc, out_instr);
    end
  endtask

  // Model: the consumed stream is sequential from the last redirect target, each word matching its address
  task automatic test_random();
    logic [63:0] expPc = 64'h8000_0000;
    logic [63:0] reqA = '0, prevAddr = '0, prevOutPc = '0;
    logic [31:0] prevInstr = '0;
    logic busy = 1'b0, prevValid = 1'b0, prevOk = 1'b0;
    logic prevOutValid = 1'b0, prevHold = 1'b0, prevRedir = 1'b0;
    int cnt = 0, consumed = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (stallI !== !out_valid) begin
        fails++;
        $display("FAIL rnd_stall[%0d] got=%b exp=%b", c, stallI, !out_valid);
      end
      if (out_valid) begin
        checks++;
        if (out_pc !== expPc || out_instr !== word(expPc) || ireq_valid !== 1'b0) begin
          fails++;
          $display("FAIL rnd_out[%0d] got pc=%h i=%h rq=%b exp pc=%h i=%h rq=0",
                   c, out_pc, out_instr, ireq_valid, expPc, word(expPc));
        end
      end
      if (prevValid && !prevOk) begin
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== prevAddr) begin
          fails++;
          $display("FAIL rnd_req_stable[%0d] got rq=%b a=%h exp rq=1 a=%h", c, ireq_valid, ireq_addr, prevAddr);
        end
      end
      if (prevOutValid && prevHold && !prevRedir) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== prevOutPc || out_instr !== prevInstr) begin
          fails++;
          $display("FAIL rnd_hold[%0d] got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                   c, out_valid, out_pc, out_instr, prevOutPc, prevInstr);
        end
      end
      if (!busy && ireq_valid) begin
        busy = 1'b1;
        reqA = ireq_addr;
        cnt = $urandom_range(0, 2);
      end
      iresp_ok = busy && cnt == 0;
      iresp_data = iresp_ok ? word(reqA) : $urandom;
      if (iresp_ok) busy = 1'b0;
      else if (busy) cnt--;
      hold = $urandom_range(0, 2) == 0;
      redirect = $urandom_range(0, 11) == 0;
      redirect_pc = 64'h8000_0000 + 64'($urandom_range(0, 1023));
      if (out_valid && !hold && !redirect) begin
        expPc = expPc + 64'd4;
        consumed++;
      end
      if (redirect) expPc = redirect_pc;
      prevValid = ireq_valid;
      prevAddr = ireq_addr;
      prevOk = iresp_ok;
      prevOutValid = out_valid;
      prevOutPc = out_pc;
      prevInstr = out_instr;
      prevHold = hold;
      prevRedir = redirect;
      tick();
    end
    iresp_ok = 1'b0;
    redirect = 1'b0;
    hold = 1'b0;
    checks++;
    if (consumed < 200) begin
      fails++;
      $display("FAIL rnd_progress got=%0d exp>=200", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_hold();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_reset_discard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
